// File: rtl/bcd_scan_pkg.sv
// Shared types for the BCD scan controller.
//   field_t : one 6-bit binary stopwatch field
//   digit_t : one BCD digit
//   state_t : conversion-pass FSM states
//   digits(): number of displayed digits for a given field count
package bcd_scan_pkg;

    typedef logic [5:0] field_t;
    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SAMPLE,
        COMMIT
    } state_t;

    function automatic int unsigned digits(input int unsigned n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/bcd_scan_div.sv
// Digit-scan prescaler: emits a one-cycle tick every SCAN_DIV clock cycles.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous reset, active low
//   tick out  one-cycle pulse, first one SCAN_DIV cycles after reset release
module bcd_scan_div #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-shares one external 6-bit-to-BCD converter across NUM_FIELDS stopwatch fields and
// drives a multiplexed 7-segment digit scan. A pass fills a shadow bank, which is copied to
// the display bank in a single cycle so the display never shows a torn value.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active low
//   field_bin  in   field f at [6f+5:6f]; field 0 is rightmost
//   upd        in   update request pulse
//   busy       out  conversion pass in progress
//   cnv_data   out  registered converter operand
//   cnv_unit   in   converter units result
//   cnv_ten    in   converter tens result
//   dig_sel    out  active-low digit enables
//   dig_bcd    out  BCD value of the enabled digit
//   dig_dp     out  decimal point (units digit of fields 1..NUM_FIELDS-1)
// Build option: LEADING_ZERO_BLANK_EN blanks the most significant digit when it is zero.
module bcd_scan_ctrl
    import bcd_scan_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = 3,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [6*NUM_FIELDS-1:0]      field_bin,
    input  logic                         upd,
    output logic                         busy,
    output logic [5:0]                   cnv_data,
    input  logic [3:0]                   cnv_unit,
    input  logic [3:0]                   cnv_ten,
    output logic [2*NUM_FIELDS-1:0]      dig_sel,
    output logic [3:0]                   dig_bcd,
    output logic                         dig_dp
);

    localparam int unsigned DIGITS = digits(NUM_FIELDS);
    localparam int unsigned IW     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int unsigned DW     = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FIELDS - 1);
    localparam logic [DW-1:0] LAST_DIG = DW'(DIGITS - 1);

    // ---------------- conversion pass ----------------
    state_t                        state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic                          pend_q, pend_d;
    field_t [NUM_FIELDS-1:0]       snap_q, snap_d;
    field_t                        cnv_data_q, cnv_data_d;
    logic [NUM_FIELDS-1:0][7:0]    shadow_q, shadow_d;
    logic [NUM_FIELDS-1:0][7:0]    disp_q, disp_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        snap_d     = snap_q;
        cnv_data_d = cnv_data_q;
        shadow_d   = shadow_q;
        disp_d     = disp_q;

        // Requests arriving mid-pass collapse into one extra pass; COMMIT handles upd itself.
        if (upd && (state_q == LOAD || state_q == SAMPLE)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (upd) begin
                    snap_d  = field_bin;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnv_data_d = snap_q[idx_q];
                state_d    = SAMPLE;
            end
            SAMPLE: begin
                shadow_d[idx_q] = {cnv_ten, cnv_unit};
                if (idx_q == LAST_IDX) begin
                    state_d = COMMIT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD;
                end
            end
            COMMIT: begin
                disp_d = shadow_q;
                pend_d = 1'b0;
                if (pend_q || upd) begin
                    snap_d  = field_bin;
                    idx_d   = '0;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            snap_q     <= '0;
            cnv_data_q <= '0;
            shadow_q   <= '0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            snap_q     <= snap_d;
            cnv_data_q <= cnv_data_d;
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign cnv_data = cnv_data_q;

    // ---------------- digit scan ----------------
    logic                tick;
    logic [DW-1:0]       scan_idx_q;
    logic [DIGITS-1:0]   dig_sel_q;
    digit_t              dig_bcd_q;
    logic                dig_dp_q;

    logic [IW-1:0]       scan_field;
    digit_t              cur_digit;
    logic                cur_dp;
    logic                blank;

    bcd_scan_div #(
        .SCAN_DIV (SCAN_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        scan_field = IW'(scan_idx_q >> 1);
        cur_digit  = scan_idx_q[0] ? disp_q[scan_field][7:4] : disp_q[scan_field][3:0];
        cur_dp     = !scan_idx_q[0] && (scan_field != '0);
`ifdef LEADING_ZERO_BLANK_EN
        blank      = (scan_idx_q == LAST_DIG) && (cur_digit == 4'd0);
`else
        blank      = 1'b0;
`endif
    end

    // scan_idx_q names the digit to be shown on the next tick, so the first tick shows d=0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_idx_q <= '0;
            dig_sel_q  <= '1;
            dig_bcd_q  <= '0;
            dig_dp_q   <= 1'b0;
        end else if (tick) begin
            scan_idx_q <= (scan_idx_q == LAST_DIG) ? '0 : scan_idx_q + 1'b1;
            dig_sel_q  <= blank ? '1 : ~(DIGITS'(1) << scan_idx_q);
            dig_bcd_q  <= blank ? 4'd0 : cur_digit;
            dig_dp_q   <= cur_dp && !blank;
        end
    end

    assign dig_sel = dig_sel_q;
    assign dig_bcd = dig_bcd_q;
    assign dig_dp  = dig_dp_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed self-checking bench for bcd_scan_ctrl (NUM_FIELDS=3, SCAN_DIV=4).
module tb_bcd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] field_bin;
    logic        upd;
    logic        busy;
    logic [5:0]  cnv_data;
    logic [3:0]  cnv_unit;
    logic [3:0]  cnv_ten;
    logic [5:0]  dig_sel;
    logic [3:0]  dig_bcd;
    logic        dig_dp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External converter model
    assign cnv_ten  = 4'(cnv_data / 6'd10);
    assign cnv_unit = 4'(cnv_data % 6'd10);

    bcd_scan_ctrl #(
        .NUM_FIELDS (3),
        .SCAN_DIV   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .field_bin (field_bin),
        .upd       (upd),
        .busy      (busy),
        .cnv_data  (cnv_data),
        .cnv_unit  (cnv_unit),
        .cnv_ten   (cnv_ten),
        .dig_sel   (dig_sel),
        .dig_bcd   (dig_bcd),
        .dig_dp    (dig_dp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for digit d's scan slot, then check its value and decimal point.
    task automatic check_digit(input int d, input int bcd, input int dp, input string tag);
        logic [5:0] want;
        bit         found;
        want  = ~(6'b1 << d);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (dig_sel === want) found = 1'b1;
        end
        check({tag, "_slot"}, 32'(found), 32'd1);
        check({tag, "_bcd"}, 32'(dig_bcd), 32'(bcd));
        check({tag, "_dp"}, 32'(dig_dp), 32'(dp));
    endtask

    initial begin
        rst       = 1'b0;
        upd       = 1'b0;
        field_bin = '0;

        // 1: reset state and first tick
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnv", 32'(cnv_data), 32'd0);
        check("rst_sel", 32'(dig_sel), 32'h3f);
        check("rst_bcd", 32'(dig_bcd), 32'd0);
        check("rst_dp", 32'(dig_dp), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_tick_sel", 32'(dig_sel), 32'h3f);
        @(negedge clk);
        check("first_tick_sel", 32'(dig_sel), 32'h3e);
        check("first_tick_bcd", 32'(dig_bcd), 32'd0);

        // 2: single pass {12,34,56}
        field_bin = {6'd12, 6'd34, 6'd56};
        upd = 1'b1;
        @(negedge clk);                       // after t
        upd = 1'b0;
        check("p2_busy_t1", 32'(busy), 32'd1);
        @(negedge clk);                       // after t+1
        check("p2_cnv0", 32'(cnv_data), 32'd56);
        repeat (2) @(negedge clk);            // after t+3
        check("p2_cnv1", 32'(cnv_data), 32'd34);
        repeat (2) @(negedge clk);            // after t+5
        check("p2_cnv2", 32'(cnv_data), 32'd12);
        @(negedge clk);                       // after t+6
        check("p2_busy_t6", 32'(busy), 32'd1);
        @(negedge clk);                       // after t+7
        check("p2_busy_t7", 32'(busy), 32'd0);
        check_digit(0, 6, 0, "p2_d0");
        check_digit(1, 5, 0, "p2_d1");
        check_digit(2, 4, 1, "p2_d2");
        check_digit(3, 3, 0, "p2_d3");
        check_digit(4, 2, 1, "p2_d4");
        check_digit(5, 1, 0, "p2_d5");

        // 3: requests mid-pass collapse into one extra pass
        field_bin = {6'd12, 6'd34, 6'd57};
        upd = 1'b1;
        @(negedge clk);                       // after t
        upd = 1'b0;
        repeat (2) @(negedge clk);            // after t+2
        upd = 1'b1;
        @(negedge clk);                       // after t+3
        upd = 1'b0;
        @(negedge clk);                       // after t+4
        upd = 1'b1;
        @(negedge clk);                       // after t+5
        upd = 1'b0;
        repeat (2) @(negedge clk);            // after t+7
        check("p3_busy_t7", 32'(busy), 32'd1);
        @(negedge clk);                       // after t+8
        check("p3_cnv_t8", 32'(cnv_data), 32'd57);
        repeat (5) @(negedge clk);            // after t+13
        check("p3_busy_t13", 32'(busy), 32'd1);
        @(negedge clk);                       // after t+14
        check("p3_busy_t14", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("p3_no_third", 32'(busy), 32'd0);
        check_digit(0, 7, 0, "p3_d0");

        // 4: edge values {0,63,9}
        field_bin = {6'd0, 6'd63, 6'd9};
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        repeat (8) @(negedge clk);
        check("p4_idle", 32'(busy), 32'd0);
        check_digit(0, 9, 0, "p4_d0");
        check_digit(1, 0, 0, "p4_d1");
        check_digit(2, 3, 1, "p4_d2");
        check_digit(3, 6, 0, "p4_d3");
        check_digit(4, 0, 1, "p4_d4");
        check_digit(5, 0, 0, "p4_d5");

        // 5: reset during SAMPLE of field 1 discards the pass
        field_bin = {6'd11, 6'd22, 6'd33};
        upd = 1'b1;
        @(negedge clk);                       // after t
        upd = 1'b0;
        repeat (3) @(negedge clk);            // after t+3
        rst = 1'b0;
        @(negedge clk);                       // reset sampled at t+4
        rst = 1'b1;
        check("p5_busy", 32'(busy), 32'd0);
        check("p5_cnv", 32'(cnv_data), 32'd0);
        check("p5_sel", 32'(dig_sel), 32'h3f);
        repeat (12) @(negedge clk);
        check("p5_still_idle", 32'(busy), 32'd0);
        check_digit(0, 0, 0, "p5_d0");
        check_digit(1, 0, 0, "p5_d1");
        check_digit(2, 0, 1, "p5_d2");
        check_digit(3, 0, 0, "p5_d3");
        check_digit(4, 0, 1, "p5_d4");
        check_digit(5, 0, 0, "p5_d5");

        // 6: most significant digit zero {5,0,0}
        field_bin = {6'd5, 6'd0, 6'd0};
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        repeat (8) @(negedge clk);
        check_digit(4, 5, 1, "p6_d4");
        repeat (4) @(negedge clk);            // next slot is d5
`ifdef LEADING_ZERO_BLANK_EN
        check("p6_d5_sel", 32'(dig_sel), 32'h3f);
`else
        check("p6_d5_sel", 32'(dig_sel), 32'h1f);
`endif
        check("p6_d5_bcd", 32'(dig_bcd), 32'd0);
        check("p6_d5_dp", 32'(dig_dp), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
